// File: rtl/config_bus_pkg.sv
// Shared types and constants for the Config bus responder.
// The optional bypass path is enabled by defining CONFIG_RESP_BYPASS_EN.
package config_bus_pkg;

  localparam int CONFIG_DATA_W     = 8;
  localparam int CONFIG_FIFO_DEPTH = 4;
  localparam int CONFIG_CNT_W      = $clog2(CONFIG_FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

  typedef struct packed {
    logic [CONFIG_CNT_W-1:0] count;
    logic                    full;
    logic                    empty;
    logic                    overflow;
    logic                    underflow;
  } config_status_t;

  // Classify an occupancy value into its coarse state.
  function automatic occ_state_t occ_from_count(input int unsigned cnt,
                                                input int unsigned depth);
    if (cnt == 0)          return OCC_EMPTY;
    else if (cnt >= depth) return OCC_FULL;
    else                   return OCC_PARTIAL;
  endfunction

endpackage

// File: rtl/config_resp_fifo_mem.sv
// DEPTH x WIDTH storage: one write port, one registered read port.
// The read register holds its value when no read is requested and
// clears on reset so the bus sees zero before the first pop.
module config_resp_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Registered read; a read and write to the same slot returns the old word.
  always_ff @(posedge clk) begin
    if (!rst_n)       rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/config_fifo_responder.sv
// Config bus slave endpoint: r_en queues write_data, w_en pops the oldest
// word onto read_data one cycle later. Exposes occupancy and sticky errors.
// Optional feature macro: CONFIG_RESP_BYPASS_EN (forward write_data when
// empty and both strobes arrive together).
// Handshake: there is no back-pressure; a strobe is a one-cycle request that
// either succeeds or sets the matching sticky error flag.
module config_fifo_responder
  import config_bus_pkg::*;
#(
  parameter int WIDTH  = CONFIG_DATA_W,
  parameter int DEPTH  = CONFIG_FIFO_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r_en,
  input  logic             w_en,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] read_data,
  output logic             read_valid,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int PTR_W = $clog2(DEPTH);

  occ_state_t       occ_q, occ_d;
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             rvalid_q, rvalid_d;
  logic             empty_now, full_now;
  logic             pop_ok, push_ok, bypass;
  logic [WIDTH-1:0] mem_rd_data;

  assign empty_now = (occ_q == OCC_EMPTY);
  assign full_now  = (occ_q == OCC_FULL);

`ifdef CONFIG_RESP_BYPASS_EN
  assign bypass = r_en && w_en && empty_now;
`else
  assign bypass = 1'b0;
`endif

  // Strobe decode, pointer/count/flag next state and occupancy transition.
  always_comb begin
    pop_ok   = w_en && !empty_now;
    push_ok  = r_en && (!full_now || pop_ok) && !bypass;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rvalid_d = pop_ok || bypass;
    if (push_ok) wptr_d = wptr_q + PTR_W'(1);
    if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    // A new error event in the clear cycle wins over the clear.
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (r_en && full_now && !pop_ok)   ovf_d = 1'b1;
    if (w_en && empty_now && !bypass)  unf_d = 1'b1;
    occ_d = occ_from_count(int'(count_d), DEPTH);
  end

  // State registers; reset discards all queued words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q    <= OCC_EMPTY;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      occ_q    <= occ_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rvalid_q <= rvalid_d;
    end
  end

  config_resp_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (push_ok),
    .wr_addr_i (wptr_q),
    .wr_data_i (write_data),
    .rd_en_i   (pop_ok),
    .rd_addr_i (rptr_q),
    .rd_data_o (mem_rd_data)
  );

`ifdef CONFIG_RESP_BYPASS_EN
  logic             sel_byp_q;
  logic [WIDTH-1:0] byp_data_q;

  // Remember whether the last delivered word came from the bypass path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_byp_q  <= 1'b0;
      byp_data_q <= '0;
    end else if (bypass) begin
      sel_byp_q  <= 1'b1;
      byp_data_q <= write_data;
    end else if (pop_ok) begin
      sel_byp_q  <= 1'b0;
    end
  end

  assign read_data = sel_byp_q ? byp_data_q : mem_rd_data;
`else
  assign read_data = mem_rd_data;
`endif

  assign read_valid = rvalid_q;
  assign count      = count_q;
  assign full       = (occ_q == OCC_FULL);
  assign empty      = (occ_q == OCC_EMPTY);
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_config_fifo_responder.sv
// Bench for config_fifo_responder: directed sequences followed by random
// strobes, every cycle checked against a queue-based reference model.
module tb_config_fifo_responder;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef CONFIG_RESP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             r_en = 1'b0, w_en = 1'b0, clr_err = 1'b0;
  logic [W-1:0]     write_data = '0;
  logic [W-1:0]     read_data;
  logic             read_valid, full, empty, overflow, underflow;
  logic [CNT_W-1:0] count;

  config_fifo_responder #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .r_en       (r_en),
    .w_en       (w_en),
    .write_data (write_data),
    .read_data  (read_data),
    .read_valid (read_valid),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .underflow  (underflow),
    .clr_err    (clr_err)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_rd;
  logic         exp_rv, exp_ovf, exp_unf;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Behavioural view of one clock edge, from the FIFO rules.
  task automatic model_edge(input logic r, input logic w, input logic clr,
                            input logic rst, input logic [W-1:0] d);
    int  occ;
    bit  was_empty, was_full, pop, byp, ovf_set, unf_set;
    if (!rst) begin
      exp_q.delete();
      exp_rd  = '0;
      exp_rv  = 1'b0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
      return;
    end
    occ       = exp_q.size();
    was_empty = (occ == 0);
    was_full  = (occ == DEPTH);
    pop       = w && !was_empty;
    byp       = BYP && r && w && was_empty;
    ovf_set   = r && was_full && !pop;
    unf_set   = w && was_empty && !byp;
    if (pop) begin
      exp_rd = exp_q.pop_front();
      exp_rv = 1'b1;
    end else if (byp) begin
      exp_rd = d;
      exp_rv = 1'b1;
    end else begin
      exp_rv = 1'b0;
    end
    if (r && !byp && !ovf_set) exp_q.push_back(d);
    exp_ovf = ovf_set ? 1'b1 : (clr ? 1'b0 : exp_ovf);
    exp_unf = unf_set ? 1'b1 : (clr ? 1'b0 : exp_unf);
  endtask

  task automatic compare_all();
    int occ;
    occ = exp_q.size();
    check_eq("read_valid", 32'(read_valid), 32'(exp_rv));
    check_eq("read_data",  32'(read_data),  32'(exp_rd));
    check_eq("count",      32'(count),      32'(occ));
    check_eq("full",       32'(full),       32'(occ == DEPTH));
    check_eq("empty",      32'(empty),      32'(occ == 0));
    check_eq("overflow",   32'(overflow),   32'(exp_ovf));
    check_eq("underflow",  32'(underflow),  32'(exp_unf));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic w, input logic clr,
                      input logic rst, input logic [W-1:0] d);
    @(negedge clk);
    r_en = r; w_en = w; clr_err = clr; rst_n = rst; write_data = d;
    @(posedge clk);
    model_edge(r, w, clr, rst, d);
    #1;
    compare_all();
  endtask

  task automatic push(input logic [W-1:0] d); step(1, 0, 0, 1, d); endtask
  task automatic pop();                      step(0, 1, 0, 1, '0); endtask
  task automatic idle();                     step(0, 0, 0, 1, '0); endtask
  task automatic do_reset();                 step(0, 0, 0, 0, '0); endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    do_reset();
    idle();

    // Three pushes then three pops, back-to-back.
    push(8'h11); push(8'h22); push(8'h33);
    pop(); pop(); pop(); idle();

    // Overfill by one, then drain.
    for (int i = 1; i <= 5; i++) push(W'(i));
    for (int i = 0; i < 4; i++) pop();
    idle();
    step(0, 0, 1, 1, '0);

    // Pop on empty after reset, then clear.
    do_reset();
    pop(); idle();
    step(0, 0, 1, 1, '0);
    idle();

    // Full with simultaneous push and pop, then drain.
    for (int i = 0; i < 4; i++) push(W'(8'hA0 + i));
    step(1, 1, 0, 1, 8'hB4);
    for (int i = 0; i < 4; i++) pop();
    idle();

    // Both strobes on empty.
    step(0, 0, 1, 1, '0);
    step(1, 1, 0, 1, 8'h5C);
    pop(); idle();

    // Clear colliding with a new error: set must win.
    step(0, 1, 1, 1, '0);
    step(0, 0, 1, 1, '0);

    // Reset mid-operation with a push strobe present.
    push(8'h77); push(8'h88);
    step(1, 0, 0, 0, 8'h99);
    idle();
    pop();
    step(0, 0, 1, 1, '0);

    // Random traffic in phases of differing push/pop bias.
    for (int ph = 0; ph < 6; ph++) begin
      int pr, pw;
      pr = 20 + 15 * ph;
      pw = 100 - pr;
      for (int c = 0; c < 120; c++) begin
        logic r, w, clr, rst;
        r   = ($urandom_range(0, 99) < pr);
        w   = ($urandom_range(0, 99) < pw);
        clr = ($urandom_range(0, 15) == 0);
        rst = !($urandom_range(0, 199) == 0);
        step(r, w, clr, rst, W'($urandom_range(0, 255)));
      end
    end

    idle();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
